// File: rtl/keypad_pkg.sv
// Shared keypad definitions: keycode type, injector FSM states and the key-matrix map.
// The key map here is the single source of truth the scanner's decode must agree with.
// Contents: keycode_t, inj_state_t, key_to_rowcol() -> {row_idx[1:0], col_idx[1:0]}.
package keypad_pkg;

  typedef logic [3:0] keycode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    GAP   = 2'd2
  } inj_state_t;

  // Matrix position of each key:
  //   col0: 2,5,8,0   col1: 3,6,9,F   col2: A,B,C,D   col3: 1,4,7,E  (rows 0..3)
  function automatic logic [3:0] key_to_rowcol(input keycode_t k);
    logic [3:0] rc;
    rc = 4'b0000;
    case (k)
      4'h2: rc = {2'd0, 2'd0};
      4'h5: rc = {2'd1, 2'd0};
      4'h8: rc = {2'd2, 2'd0};
      4'h0: rc = {2'd3, 2'd0};
      4'h3: rc = {2'd0, 2'd1};
      4'h6: rc = {2'd1, 2'd1};
      4'h9: rc = {2'd2, 2'd1};
      4'hF: rc = {2'd3, 2'd1};
      4'hA: rc = {2'd0, 2'd2};
      4'hB: rc = {2'd1, 2'd2};
      4'hC: rc = {2'd2, 2'd2};
      4'hD: rc = {2'd3, 2'd2};
      4'h1: rc = {2'd0, 2'd3};
      4'h4: rc = {2'd1, 2'd3};
      4'h7: rc = {2'd2, 2'd3};
      4'hE: rc = {2'd3, 2'd3};
      default: rc = 4'b0000;
    endcase
    return rc;
  endfunction

endpackage

// File: rtl/keypad_key_fifo.sv
// DEPTH x W synchronous FIFO holding keycodes waiting to be typed.
// Ports: clk, reset (sync, active-low), push_i/din_i (ignored when full), pop_i (ignored when empty),
//        dout_o (head, valid while !empty_o), full_o, empty_o. Pointers carry a wrap bit for full/empty.
module keypad_key_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q;
  logic [AW:0]  rd_ptr_q;
  logic         do_push;
  logic         do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  // Storage needs no reset: pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (reset && do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/keypad_key_injector.sv
// Types queued hex keycodes into a 4x4 keypad scanner by emulating closed keys on the row lines.
// Ports: clk, reset (sync, active-low); in_valid/in_key/in_ready keycode push; col (scanner drive, active-low);
//        row (sense, active-low, 1111 = no key); busy (queue non-empty or key in progress); key_done (end of gap).
module keypad_key_injector
  import keypad_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int PRESS_CYCLES = 64,
  parameter int GAP_CYCLES   = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [3:0] in_key,
  output logic       in_ready,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic       busy,
  output logic       key_done
);

  localparam int MAXC = (PRESS_CYCLES > GAP_CYCLES) ? PRESS_CYCLES : GAP_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] PRESS_LOAD = CW'(PRESS_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD   = CW'(GAP_CYCLES - 1);

  inj_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  keycode_t      cur_key_q, cur_key_d;
  logic          key_done_q, key_done_d;

  logic     fifo_full;
  logic     fifo_empty;
  logic     fifo_pop;
  keycode_t fifo_dout;
  logic [3:0] rc;

  assign in_ready = !fifo_full;
  assign fifo_pop = (state_q == IDLE) && !fifo_empty;

  keypad_key_fifo #(
    .DEPTH (DEPTH),
    .W     (4)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (in_valid),
    .pop_i   (fifo_pop),
    .din_i   (in_key),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      cur_key_q  <= '0;
      key_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cur_key_q  <= cur_key_d;
      key_done_q <= key_done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cur_key_d  = cur_key_q;
    key_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          cur_key_d = fifo_dout;
          cnt_d     = PRESS_LOAD;
          state_d   = PRESS;
        end
      end
      PRESS: begin
        if (cnt_q == '0) begin
          cnt_d   = GAP_LOAD;
          state_d = GAP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          key_done_d = 1'b1;
          state_d    = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign key_done = key_done_q;
  assign busy     = (state_q != IDLE) || !fifo_empty;

  // A closed key connects its row to its column, so the row follows that column's drive.
  // col=0000 (scanner wait state) therefore also shows the key.
  always_comb begin
    rc  = key_to_rowcol(cur_key_q);
    row = 4'b1111;
    if (state_q == PRESS) row[rc[3:2]] = ~|(~col & (4'b0001 << rc[1:0]));
  end

endmodule
